decode_stage_pipe: RTL and testbench
====================================

// Module: decode_stage_pipe
// PURPOSE
//  RV32I decode stage plus ID/EX pipeline register, parametrised successor of the fixed-width decode cycle.
//  Decodes the instruction, reads the register file (write-first bypass from WB) and sign-extends the immediate.
//  Adds load-use hazard detection (stall_fd), branch flush, valid tracking and a registered rs1/rs2 to EX for forwarding.
//  Sits between the fetch stage (IF/ID register) and the execute stage.
// PARAMETERS
//  XLEN      32  datapath width; pc and immediate width
//  NREGS     32  architectural registers; address width RW = $clog2(NREGS)
//  ALUC_W    3   ALU control width
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      synchronous, active-high reset
//  instr_d     in   32     instruction in D
//  pc_d        in   XLEN   pc of instr_d
//  pcplus4_d   in   XLEN   pc_d + 4
//  valid_d     in   1      instr_d is a real instruction
//  flush_e     in   1      taken branch resolved in EX: kill the instruction entering E
//  regwrite_w  in   1      WB write enable
//  rd_w        in   RW     WB destination
//  result_w    in   XLEN   WB data
//  stall_fd    out  1      comb: hold PC and IF/ID (load-use hazard)
//  valid_e, regwrite_e, alusrc_e, memwrite_e, resultsrc_e, branch_e  out 1 each  registered controls
//  illegal_e   out  1      registered: valid_d with unsupported opcode
//  aluctrl_e   out  ALUC_W registered ALU control
//  rd1_e, rd2_e, imm_e   out XLEN  registered operands / extended immediate
//  rs1_e, rs2_e, rd_e    out RW    registered register addresses
//  pc_e, pcplus4_e       out XLEN  registered pc values
// BEHAVIOUR
//  - Reset: every E output, and every register-file entry, is 0 at the first edge with rst=1.
//  - Latency: one cycle D->E. Per edge, priority rst > flush_e > stall_fd (bubble) > load.
//  - Load: all E outputs take their decoded D values; valid_e = valid_d.
//  - Bubble (flush_e, or stall_fd): valid_e, regwrite_e, memwrite_e, branch_e, resultsrc_e, illegal_e = 0;
//    every other E output is 0. flush_e and stall_fd in the same cycle: bubble (flush wins, same result).
//  - stall_fd = valid_e & resultsrc_e & (rd_e != 0) & valid_d & (rd_e == rs1_d | rd_e == rs2_d);
//    rs2_d compared only for R/S/B formats. Asserted one cycle per load-use, then the repeat clears it.
//  - Any control with valid_d = 0 is forced to 0 (valid_e = 0) before the register.
//  - Register file: x0 reads 0; writes ignored for rd_w = 0; write on edge when regwrite_w.
//    Read bypass: if regwrite_w & rd_w == addr & addr != 0, the read returns result_w in the same cycle.
//  - Decode (opcode -> RegWrite ALUSrc MemWrite ResultSrc Branch ImmSrc):
//    0000011 lw 1 1 0 1 0 I | 0100011 sw 0 1 1 0 0 S | 0110011 R 1 0 0 0 0 - |
//    0010011 I-alu 1 1 0 0 0 I | 1100011 beq 0 0 0 0 1 B | other: all 0, illegal = valid_d.
//  - ALU control: lw/sw add 000; beq sub 001; R/I by funct3: 000 add (sub 001 if R & funct7[5]), 010 slt 101,
//    110 or 011, 111 and 010; other funct3: 000.
//  - Immediate: I = sext(instr[31:20]); S = sext({instr[31:25], instr[11:7]});
//    B = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}); sign bit instr[31], extended to XLEN.
//  - rst mid-stall: stall state is purely comb from E regs, so it clears with the reset.
// STRUCTURE
//  - Package decode_pkg: opcode constants, ALU control codes, ImmSrc enum (IMM_I, IMM_S, IMM_B), control struct typedef.
//  - Sub-module decode_regfile (NREGS x XLEN, 2 read / 1 write, sync reset, write-first bypass).
//  - Decoder, immediate extension, hazard compare and the ID/EX register live in this module.
// TESTING
//  1. Reset 3 cycles with valid_d=1 instr 0x00500093 -> all E outputs 0 during reset; first edge after: regwrite_e=1,
//     alusrc_e=1, imm_e=5, rd_e=1.
//  2. WB x5=0xDEADBEEF same cycle as D reads x5 (add x6,x5,x0) -> rd1_e=0xDEADBEEF next edge; WB to x0 -> x0 still 0.
//  3. lw x2,0(x1) in E, D = add x3,x2,x4 -> stall_fd=1 one cycle, bubble (valid_e=0), then add loads, stall_fd=0.
//  4. lw x0 in E, D reads x0 -> stall_fd=0.
//  5. flush_e=1 with valid sw in D -> valid_e=0, memwrite_e=0; flush_e and stall_fd together -> single bubble.
//  6. beq with B-imm -8 (0xFE000CE3) -> branch_e=1, aluctrl_e=001, imm_e=0xFFFFFFF8; opcode 0x7F -> illegal_e=1, regwrite_e=0.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, ALU control codes, immediate formats
// and the per-instruction control bundle.
package decode_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    IMM_I = 2'd0,
    IMM_S = 2'd1,
    IMM_B = 2'd2
  } immsrc_e;

  typedef struct packed {
    logic regwrite;
    logic alusrc;
    logic memwrite;
    logic resultsrc;
    logic branch;
    logic illegal;
  } ctrl_t;

  // Only R, S and B formats carry a real rs2 field.
  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// Architectural register file: 2 read / 1 write, x0 hardwired to zero,
// synchronous clear, write-first bypass so WB data is visible to D in the same cycle.
module decode_regfile
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int RW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RW-1:0]   i_ra1,
  input  logic [RW-1:0]   i_ra2,
  input  logic            i_we,
  input  logic [RW-1:0]   i_wa,
  input  logic [XLEN-1:0] i_wd,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2
);

  logic [XLEN-1:0] r_mem [NREGS];
  logic            w_byp1;
  logic            w_byp2;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_we && (i_wa != '0)) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign w_byp1 = i_we && (i_wa == i_ra1);
  assign w_byp2 = i_we && (i_wa == i_ra2);

  assign o_rd1 = (i_ra1 == '0) ? '0 : (w_byp1 ? i_wd : r_mem[i_ra1]);
  assign o_rd2 = (i_ra2 == '0) ? '0 : (w_byp2 ? i_wd : r_mem[i_ra2]);

endmodule

// File: rtl/decode_stage_pipe.sv
// RV32I decode stage with ID/EX pipeline register: decode, register read,
// immediate extension, load-use hazard detection and branch flush.
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int ALUC_W = 3,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_d,
  input  logic [XLEN-1:0]   pc_d,
  input  logic [XLEN-1:0]   pcplus4_d,
  input  logic              valid_d,
  input  logic              flush_e,
  input  logic              regwrite_w,
  input  logic [RW-1:0]     rd_w,
  input  logic [XLEN-1:0]   result_w,
  output logic              stall_fd,
  output logic              valid_e,
  output logic              regwrite_e,
  output logic              alusrc_e,
  output logic              memwrite_e,
  output logic              resultsrc_e,
  output logic              branch_e,
  output logic              illegal_e,
  output logic [ALUC_W-1:0] aluctrl_e,
  output logic [XLEN-1:0]   rd1_e,
  output logic [XLEN-1:0]   rd2_e,
  output logic [XLEN-1:0]   imm_e,
  output logic [RW-1:0]     rs1_e,
  output logic [RW-1:0]     rs2_e,
  output logic [RW-1:0]     rd_e,
  output logic [XLEN-1:0]   pc_e,
  output logic [XLEN-1:0]   pcplus4_e
);

  logic [6:0]        w_op;
  logic [2:0]        w_f3;
  logic [RW-1:0]     w_rs1;
  logic [RW-1:0]     w_rs2;
  logic [RW-1:0]     w_rd;
  ctrl_t             w_dec;
  ctrl_t             w_ctrl;
  immsrc_e           w_immsrc;
  logic [ALUC_W-1:0] w_alu;
  logic [ALUC_W-1:0] w_aluc;
  logic [XLEN-1:0]   w_imm;
  logic [XLEN-1:0]   w_rd1;
  logic [XLEN-1:0]   w_rd2;
  logic              w_stall;
  logic              w_bubble;

  function automatic logic [ALUC_W-1:0] alu_op(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  return sub ? ALUC_W'(ALU_SUB) : ALUC_W'(ALU_ADD);
      3'b010:  return ALUC_W'(ALU_SLT);
      3'b110:  return ALUC_W'(ALU_OR);
      3'b111:  return ALUC_W'(ALU_AND);
      default: return ALUC_W'(ALU_ADD);
    endcase
  endfunction

  function automatic logic [XLEN-1:0] ext_imm(input logic [31:0] ins, input immsrc_e src);
    case (src)
      IMM_S:   return {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   return {{(XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      default: return {{(XLEN-12){ins[31]}}, ins[31:20]};
    endcase
  endfunction

  assign w_op  = instr_d[6:0];
  assign w_f3  = instr_d[14:12];
  assign w_rd  = instr_d[7 +: RW];
  assign w_rs1 = instr_d[15 +: RW];
  assign w_rs2 = instr_d[20 +: RW];

  always_comb begin
    w_dec    = '0;
    w_immsrc = IMM_I;
    w_alu    = ALUC_W'(ALU_ADD);
    case (w_op)
      OP_LW: begin
        w_dec.regwrite  = 1'b1;
        w_dec.alusrc    = 1'b1;
        w_dec.resultsrc = 1'b1;
      end
      OP_SW: begin
        w_dec.alusrc   = 1'b1;
        w_dec.memwrite = 1'b1;
        w_immsrc       = IMM_S;
      end
      OP_R: begin
        w_dec.regwrite = 1'b1;
        w_alu          = alu_op(w_f3, instr_d[30]);
      end
      OP_I: begin
        w_dec.regwrite = 1'b1;
        w_dec.alusrc   = 1'b1;
        w_alu          = alu_op(w_f3, 1'b0);
      end
      OP_BEQ: begin
        w_dec.branch = 1'b1;
        w_immsrc     = IMM_B;
        w_alu        = ALUC_W'(ALU_SUB);
      end
      default: w_dec.illegal = 1'b1;
    endcase
  end

  // A non-instruction must never carry side-effecting controls into E.
  assign w_ctrl = valid_d ? w_dec : '0;
  assign w_aluc = valid_d ? w_alu : '0;
  assign w_imm  = ext_imm(instr_d, w_immsrc);

  decode_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .i_ra1 (w_rs1),
    .i_ra2 (w_rs2),
    .i_we  (regwrite_w),
    .i_wa  (rd_w),
    .i_wd  (result_w),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2)
  );

  // Load in E whose destination is read in D: hold F/D one cycle and bubble E.
  assign w_stall = valid_e && resultsrc_e && (rd_e != '0) && valid_d &&
                   ((rd_e == w_rs1) || (uses_rs2(w_op) && (rd_e == w_rs2)));
  assign stall_fd = w_stall;
  assign w_bubble = flush_e || w_stall;

  // ---- ID/EX boundary ----
  always_ff @(posedge clk) begin
    if (rst || w_bubble) begin
      valid_e     <= 1'b0;
      regwrite_e  <= 1'b0;
      alusrc_e    <= 1'b0;
      memwrite_e  <= 1'b0;
      resultsrc_e <= 1'b0;
      branch_e    <= 1'b0;
      illegal_e   <= 1'b0;
      aluctrl_e   <= '0;
      rd1_e       <= '0;
      rd2_e       <= '0;
      imm_e       <= '0;
      rs1_e       <= '0;
      rs2_e       <= '0;
      rd_e        <= '0;
      pc_e        <= '0;
      pcplus4_e   <= '0;
    end else begin
      valid_e     <= valid_d;
      regwrite_e  <= w_ctrl.regwrite;
      alusrc_e    <= w_ctrl.alusrc;
      memwrite_e  <= w_ctrl.memwrite;
      resultsrc_e <= w_ctrl.resultsrc;
      branch_e    <= w_ctrl.branch;
      illegal_e   <= w_ctrl.illegal;
      aluctrl_e   <= w_aluc;
      rd1_e       <= w_rd1;
      rd2_e       <= w_rd2;
      imm_e       <= w_imm;
      rs1_e       <= w_rs1;
      rs2_e       <= w_rs2;
      rd_e        <= w_rd;
      pc_e        <= pc_d;
      pcplus4_e   <= pcplus4_d;
    end
  end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: a reference decoder/register-file model
// feeds a scoreboard queue that is compared against the E outputs after each edge.
module tb_decode_stage_pipe;

  localparam int XLEN = 32, NREGS = 32, ALUC_W = 3, RW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       instr_d;
  logic [XLEN-1:0]   pc_d, pcplus4_d, result_w;
  logic              valid_d, flush_e, regwrite_w;
  logic [RW-1:0]     rd_w;
  logic              stall_fd, valid_e, regwrite_e, alusrc_e, memwrite_e, resultsrc_e, branch_e, illegal_e;
  logic [ALUC_W-1:0] aluctrl_e;
  logic [XLEN-1:0]   rd1_e, rd2_e, imm_e, pc_e, pcplus4_e;
  logic [RW-1:0]     rs1_e, rs2_e, rd_e;

  always #5 clk = ~clk;

  decode_stage_pipe #(.XLEN(XLEN), .NREGS(NREGS), .ALUC_W(ALUC_W)) dut (
    .clk(clk), .rst(rst), .instr_d(instr_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d),
    .valid_d(valid_d), .flush_e(flush_e), .regwrite_w(regwrite_w), .rd_w(rd_w),
    .result_w(result_w), .stall_fd(stall_fd), .valid_e(valid_e), .regwrite_e(regwrite_e),
    .alusrc_e(alusrc_e), .memwrite_e(memwrite_e), .resultsrc_e(resultsrc_e),
    .branch_e(branch_e), .illegal_e(illegal_e), .aluctrl_e(aluctrl_e), .rd1_e(rd1_e),
    .rd2_e(rd2_e), .imm_e(imm_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .pc_e(pc_e), .pcplus4_e(pcplus4_e)
  );

  typedef struct packed {
    logic        valid, regwrite, alusrc, memwrite, resultsrc, branch, illegal;
    logic [2:0]  aluc;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc, pcp4;
  } eout_t;

  typedef struct {
    eout_t e;
    bit    chk_imm;
  } sb_t;

  sb_t         sbq[$];
  eout_t       last_e;
  logic [31:0] ref_rf [32];
  logic [31:0] cur_pc = 32'h0000_1000;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ref_alu(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  return sub ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic sb_t ref_dec(input logic [31:0] ins, input logic v);
    sb_t s;
    s.e = '0;
    s.chk_imm = 1'b1;
    case (ins[6:0])
      7'b0000011: begin
        s.e.regwrite = 1; s.e.alusrc = 1; s.e.resultsrc = 1;
        s.e.imm = {{20{ins[31]}}, ins[31:20]};
      end
      7'b0100011: begin
        s.e.alusrc = 1; s.e.memwrite = 1;
        s.e.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      7'b0110011: begin
        s.e.regwrite = 1; s.e.aluc = ref_alu(ins[14:12], ins[30]); s.chk_imm = 1'b0;
      end
      7'b0010011: begin
        s.e.regwrite = 1; s.e.alusrc = 1; s.e.aluc = ref_alu(ins[14:12], 1'b0);
        s.e.imm = {{20{ins[31]}}, ins[31:20]};
      end
      7'b1100011: begin
        s.e.branch = 1; s.e.aluc = 3'b001;
        s.e.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      default: begin
        s.e.illegal = 1; s.chk_imm = 1'b0;
      end
    endcase
    if (!v) begin
      s.e.regwrite = 0; s.e.alusrc = 0; s.e.memwrite = 0; s.e.resultsrc = 0;
      s.e.branch = 0; s.e.illegal = 0; s.e.aluc = '0;
    end
    s.e.valid = v;
    return s;
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] a, input logic we,
                                          input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
    if (we && wa == a) return wd;
    return ref_rf[a];
  endfunction

  task automatic step(input logic r, input logic [31:0] ins, input logic v, input logic fl,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd, input string tag);
    sb_t  s;
    sb_t  g;
    logic u2;
    logic exp_stall;
    @(negedge clk);
    rst = r; instr_d = ins; valid_d = v; flush_e = fl;
    regwrite_w = we; rd_w = wa; result_w = wd;
    pc_d = cur_pc; pcplus4_d = cur_pc + 32'd4;
    u2 = (ins[6:0] == 7'b0110011) || (ins[6:0] == 7'b0100011) || (ins[6:0] == 7'b1100011);
    exp_stall = last_e.valid & last_e.resultsrc & (last_e.rd != 5'd0) & v &
                ((last_e.rd == ins[19:15]) | (u2 & (last_e.rd == ins[24:20])));
    #1;
    chk({tag, ":stall"}, 128'(stall_fd), 128'(exp_stall));
    s = ref_dec(ins, v);
    s.e.rs1 = ins[19:15]; s.e.rs2 = ins[24:20]; s.e.rd = ins[11:7];
    s.e.pc = cur_pc; s.e.pcp4 = cur_pc + 32'd4;
    s.e.rd1 = rf_read(ins[19:15], we, wa, wd);
    s.e.rd2 = rf_read(ins[24:20], we, wa, wd);
    if (r || fl || exp_stall) s.e = '0;
    sbq.push_back(s);
    if (r) begin
      for (int i = 0; i < 32; i++) ref_rf[i] = 32'h0;
    end else if (we && wa != 5'd0) begin
      ref_rf[wa] = wd;
    end
    cur_pc = cur_pc + 32'd4;
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk({tag, ":sb_empty"}, 128'd1, 128'd0);
    end else begin
      g = sbq.pop_front();
      chk({tag, ":ctrl"},
          128'({valid_e, regwrite_e, alusrc_e, memwrite_e, resultsrc_e, branch_e, illegal_e, aluctrl_e}),
          128'({g.e.valid, g.e.regwrite, g.e.alusrc, g.e.memwrite, g.e.resultsrc, g.e.branch,
                g.e.illegal, g.e.aluc}));
      chk({tag, ":ops"}, 128'({rd1_e, rd2_e}), 128'({g.e.rd1, g.e.rd2}));
      chk({tag, ":regs"}, 128'({rs1_e, rs2_e, rd_e}), 128'({g.e.rs1, g.e.rs2, g.e.rd}));
      chk({tag, ":pc"}, 128'({pc_e, pcplus4_e}), 128'({g.e.pc, g.e.pcp4}));
      if (g.chk_imm) chk({tag, ":imm"}, 128'(imm_e), 128'(g.e.imm));
      last_e = g.e;
    end
  endtask

  initial begin
    rst = 1'b1; instr_d = 32'h00500093; valid_d = 1'b1; flush_e = 1'b0;
    regwrite_w = 1'b0; rd_w = '0; result_w = '0; pc_d = '0; pcplus4_d = '0;
    last_e = '0;
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'h0;

    // reset, then addi x1,x0,5
    step(1, 32'h00500093, 1, 0, 0, 0, 0, "rst0");
    step(1, 32'h00500093, 1, 0, 0, 0, 0, "rst1");
    step(1, 32'h00500093, 1, 0, 0, 0, 0, "rst2");
    step(0, 32'h00500093, 1, 0, 0, 0, 0, "addi5");
    // WB bypass and x0 protection
    step(0, 32'h00028333, 1, 0, 1, 5'd5, 32'hDEADBEEF, "byp_x5");
    step(0, 32'h000003B3, 1, 0, 1, 5'd0, 32'h12345678, "wb_x0");
    step(0, 32'h00028333, 1, 0, 0, 0, 0, "read_x5");
    // load-use on rs1, rs2, and an I-type whose imm bits alias rs2
    step(0, 32'h0000A103, 1, 0, 0, 0, 0, "lw_a");
    step(0, 32'h004101B3, 1, 0, 0, 0, 0, "lu_rs1");
    step(0, 32'h004101B3, 1, 0, 0, 0, 0, "lu_rs1_go");
    step(0, 32'h0000A103, 1, 0, 0, 0, 0, "lw_b");
    step(0, 32'h002201B3, 1, 0, 0, 0, 0, "lu_rs2");
    step(0, 32'h002201B3, 1, 0, 0, 0, 0, "lu_rs2_go");
    step(0, 32'h0000A103, 1, 0, 0, 0, 0, "lw_c");
    step(0, 32'h00220193, 1, 0, 0, 0, 0, "i_nors2");
    // load to x0 never stalls
    step(0, 32'h0000A003, 1, 0, 0, 0, 0, "lw_x0");
    step(0, 32'h000001B3, 1, 0, 0, 0, 0, "rd_x0");
    // flush, and flush coinciding with a stall
    step(0, 32'h0020A223, 1, 1, 0, 0, 0, "flush_sw");
    step(0, 32'hFE20AE23, 1, 0, 0, 0, 0, "sw_neg");
    step(0, 32'h0000A103, 1, 0, 0, 0, 0, "lw_d");
    step(0, 32'h004101B3, 1, 1, 0, 0, 0, "fl_stall");
    step(0, 32'h004101B3, 1, 0, 0, 0, 0, "fl_stall_go");
    // branch, illegal, invalid slot, ALU control variants
    step(0, 32'hFE000CE3, 1, 0, 0, 0, 0, "beq_m8");
    step(0, 32'h0000007F, 1, 0, 0, 0, 0, "illegal");
    step(0, 32'h0000007F, 0, 0, 0, 0, 0, "illegal_inv");
    step(0, 32'h0000A103, 0, 0, 0, 0, 0, "lw_inv");
    step(0, 32'h004101B3, 1, 0, 0, 0, 0, "after_inv");
    step(0, 32'h403100B3, 1, 0, 0, 0, 0, "sub");
    step(0, 32'h00004033, 1, 0, 0, 0, 0, "xor_dflt");
    step(0, 32'h00112093, 1, 0, 0, 0, 0, "slti");
    step(0, 32'h00016093, 1, 0, 0, 0, 0, "ori");
    step(0, 32'h00017093, 1, 0, 0, 0, 0, "andi");
    step(0, 32'hC0010093, 1, 0, 0, 0, 0, "addi_neg");
    // reset while a load-use stall is pending also clears the register file
    step(0, 32'h0000A103, 1, 0, 0, 0, 0, "lw_e");
    step(1, 32'h004101B3, 1, 0, 0, 0, 0, "rst_stall");
    step(0, 32'h004101B3, 1, 0, 0, 0, 0, "post_rst");
    step(0, 32'h00028333, 1, 0, 0, 0, 0, "x5_cleared");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
